// File: rtl/blackjack_dealer_ctrl.sv
// Blackjack game sequencer: deal, player turns, dealer auto-draw and scoring over the
// userSelect/cardsUpdated draw handshake. Optional macro: DEALER_HIT_SOFT17_EN (dealer hits soft 17).
module blackjack_dealer_ctrl #(
    parameter int HAND_W       = 6,
    parameter int DEALER_STAND = 17,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hit,
    input  logic              stand,
    input  logic              cardsUpdated,
    input  logic [HAND_W-1:0] p1_high,
    input  logic [HAND_W-1:0] p1_low,
    input  logic [HAND_W-1:0] p2_high,
    input  logic [HAND_W-1:0] p2_low,
    input  logic [HAND_W-1:0] d_high,
    input  logic [HAND_W-1:0] d_low,
    output logic [1:0]        userSelect,
    output logic              newGame,
    output logic [1:0]        activePlayer,
    output logic              busy,
    output logic              done,
    output logic [1:0]        p1_result,
    output logic [1:0]        p2_result,
    output logic              error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [HAND_W:0] LIM21   = (HAND_W + 1)'(21);
    localparam logic [HAND_W:0] STAND_X = (HAND_W + 1)'(DEALER_STAND);

    typedef enum logic [2:0] {
        StIdle, StClear, StDeal, StP1Turn, StP2Turn, StDealerTurn, StResolve, StDone
    } state_e;
    typedef enum logic [1:0] {SubWait, SubReq, SubGap} sub_e;

    state_e            r_state;
    sub_e              r_sub;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_deal_idx;
    logic [HAND_W-1:0] r_p1_high, r_p1_low, r_p2_high, r_p2_low, r_d_high, r_d_low;

    logic [HAND_W:0] w_p1_best, w_p2_best, w_d_best;
    logic            w_p1_bust, w_p2_bust, w_d_bust, w_dealer_draw;

    function automatic logic [HAND_W:0] best(input logic [HAND_W-1:0] h, input logic [HAND_W-1:0] l);
        if ({1'b0, h} <= LIM21)        return {1'b0, h};
        else if (l != '0)              return {1'b0, l};
        else                           return {1'b0, h};
    endfunction

    function automatic logic [1:0] seat(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd3: return 2'd1;
            3'd1, 3'd4: return 2'd2;
            default:    return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] score(input logic [HAND_W:0] pb, input logic pbust);
        if (pbust)                 return 2'd1;
        else if (w_d_bust)         return 2'd3;
        else if (pb > w_d_best)    return 2'd3;
        else if (pb == w_d_best)   return 2'd2;
        else                       return 2'd1;
    endfunction

    assign w_p1_best = best(r_p1_high, r_p1_low);
    assign w_p2_best = best(r_p2_high, r_p2_low);
    assign w_d_best  = best(r_d_high, r_d_low);
    assign w_p1_bust = w_p1_best > LIM21;
    assign w_p2_bust = w_p2_best > LIM21;
    assign w_d_bust  = w_d_best > LIM21;

`ifdef DEALER_HIT_SOFT17_EN
    // Soft 17: an ace still counted as 11 (high differs from low and is not bust).
    assign w_dealer_draw = (w_d_best < STAND_X) ||
                           ((w_d_best == STAND_X) && (r_d_low != '0) &&
                            ({1'b0, r_d_high} <= LIM21) && (r_d_high != r_d_low));
`else
    assign w_dealer_draw = w_d_best < STAND_X;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_sub        <= SubWait;
            r_cnt        <= '0;
            r_deal_idx   <= '0;
            r_p1_high    <= '0;
            r_p1_low     <= '0;
            r_p2_high    <= '0;
            r_p2_low     <= '0;
            r_d_high     <= '0;
            r_d_low      <= '0;
            userSelect   <= 2'd0;
            newGame      <= 1'b0;
            activePlayer <= 2'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            p1_result    <= 2'd0;
            p2_result    <= 2'd0;
            error        <= 1'b0;
        end else begin
            newGame <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state      <= StClear;
                        newGame      <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        p1_result    <= 2'd0;
                        p2_result    <= 2'd0;
                        activePlayer <= 2'd0;
                    end
                end
                StClear: begin
                    r_state    <= StDeal;
                    r_deal_idx <= 3'd0;
                    userSelect <= 2'd1;
                    r_sub      <= SubReq;
                    r_cnt      <= '0;
                end
                StDeal, StP1Turn, StP2Turn, StDealerTurn: begin
                    case (r_sub)
                        SubReq: begin
                            if (cardsUpdated) begin
                                r_p1_high  <= p1_high;
                                r_p1_low   <= p1_low;
                                r_p2_high  <= p2_high;
                                r_p2_low   <= p2_low;
                                r_d_high   <= d_high;
                                r_d_low    <= d_low;
                                userSelect <= 2'd0;
                                r_sub      <= SubGap;
                            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                                userSelect   <= 2'd0;
                                error        <= 1'b1;
                                p1_result    <= 2'd0;
                                p2_result    <= 2'd0;
                                done         <= 1'b1;
                                busy         <= 1'b0;
                                activePlayer <= 2'd0;
                                r_sub        <= SubWait;
                                r_state      <= StDone;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                        SubGap: begin
                            // Deal draws chain back-to-back after the single idle gap cycle.
                            if (r_state == StDeal && r_deal_idx != 3'd5) begin
                                r_deal_idx <= r_deal_idx + 3'd1;
                                userSelect <= seat(r_deal_idx + 3'd1);
                                r_sub      <= SubReq;
                                r_cnt      <= '0;
                            end else begin
                                r_sub <= SubWait;
                            end
                        end
                        default: begin
                            if (r_state == StDeal) begin
                                r_state      <= StP1Turn;
                                activePlayer <= 2'd1;
                            end else if (r_state == StP1Turn) begin
                                if (w_p1_best >= LIM21 || stand) begin
                                    r_state      <= StP2Turn;
                                    activePlayer <= 2'd2;
                                end else if (hit) begin
                                    userSelect <= 2'd1;
                                    r_sub      <= SubReq;
                                    r_cnt      <= '0;
                                end
                            end else if (r_state == StP2Turn) begin
                                if (w_p2_best >= LIM21 || stand) begin
                                    if (w_p1_bust && w_p2_bust) begin
                                        r_state      <= StResolve;
                                        activePlayer <= 2'd0;
                                    end else begin
                                        r_state      <= StDealerTurn;
                                        activePlayer <= 2'd3;
                                    end
                                end else if (hit) begin
                                    userSelect <= 2'd2;
                                    r_sub      <= SubReq;
                                    r_cnt      <= '0;
                                end
                            end else begin
                                if (w_dealer_draw) begin
                                    userSelect <= 2'd3;
                                    r_sub      <= SubReq;
                                    r_cnt      <= '0;
                                end else begin
                                    r_state <= StResolve;
                                end
                            end
                        end
                    endcase
                end
                StResolve: begin
                    p1_result    <= score(w_p1_best, w_p1_bust);
                    p2_result    <= score(w_p2_best, w_p2_bust);
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    activePlayer <= 2'd0;
                    r_state      <= StDone;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/blackjack_dealer_ctrl.md
Name: blackjack_dealer_ctrl

Overview:
- Game sequencer on the requesting end of the userSelect/card protocol served by the card puller and hand manager.
- Issues per-hand draw requests (userSelect) and waits for the manager's cardsUpdated acknowledge.
- Runs initial deal, player hit/stand turns and dealer auto-draw, then scores each player against the dealer.
- Sits between the debounced button inputs and the card/hand datapath.

Parameters:
- HAND_W, 6, width of hand value inputs.
- DEALER_STAND, 17, dealer stops drawing at best value >= this.
- TIMEOUT, 64, max cycles userSelect may wait for cardsUpdated (> 52-cycle worst-case pull).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse, begin new game.
- hit  in  1  one-cycle pulse, active player draws.
- stand  in  1  one-cycle pulse, active player ends turn.
- cardsUpdated  in  1  manager ack, hand values valid this cycle.
- p1_high, p1_low, p2_high, p2_low, d_high, d_low  in  HAND_W each  manager hand values (low = 0 until an ace is held).
- userSelect  out  2  0 idle, 1 P1, 2 P2, 3 dealer.
- newGame  out  1  one-cycle pulse; system ORs into manager/puller clear.
- activePlayer  out  2  0 none, 1 P1, 2 P2, 3 dealer.
- busy  out  1  game in progress.
- done  out  1  results valid; held until next start.
- p1_result, p2_result  out  2 each  0 none, 1 lose, 2 push, 3 win.
- error  out  1  draw timeout occurred.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0.
- best(h,l) = h if h <= 21, else (l != 0 ? l : h); bust when best > 21. Compare in HAND_W+1 bits; no wrap.
- States: IDLE -> CLEAR -> DEAL -> P1_TURN -> P2_TURN -> DEALER_TURN -> RESOLVE -> DONE.
- IDLE/DONE, start=1: newGame=1 for 1 cycle in CLEAR; clear results, error, done; busy=1.
  - start while busy: ignored.
- Draw handshake (REQ/GAP substates):
  - REQ: userSelect driven and held constant until cardsUpdated=1 is sampled.
  - Next cycle, GAP: userSelect=0 for exactly 1 cycle. Next request no earlier than the cycle after GAP.
  - cardsUpdated outside REQ: ignored.
- DEAL: six draws in order 1,2,3,1,2,3.
- P1_TURN/P2_TURN (activePlayer = 1/2):
  - hit in wait state (no draw in flight): one draw for that player.
  - stand: advance to next turn.
  - Auto-advance in the cycle after a GAP where best >= 21.
  - hit/stand during a draw, or in any other state: dropped, not queued.
  - hit and stand in same cycle: stand wins.
- DEALER_TURN (activePlayer=3):
  - Skipped entirely if both players bust.
  - Draws while best(d) < DEALER_STAND; each decision made after the GAP.
- RESOLVE (1 cycle), per player:
  - player bust -> lose.
  - else dealer bust -> win.
  - else best greater -> win, equal -> push, less -> lose.
- DONE: done=1, busy=0, activePlayer=0; results held.
- Timeout:
  - Counter runs during REQ.
  - Reaching TIMEOUT cycles without cardsUpdated: userSelect=0, error=1, results=0, go to DONE.
- reset mid-draw: userSelect drops to 0 immediately (async).

Optional Feature:
- DEALER_HIT_SOFT17_EN
  - Defined: dealer also draws when best(d)==DEALER_STAND and soft (d_low!=0, d_high<=21, d_high!=d_low).
  - Undefined: dealer stands on any best >= DEALER_STAND.

Test Plan:
- Deal sequencing:
  - Stimulus: start, model acks 3 cycles after each request.
  - Required: userSelect sequence 1,2,3,1,2,3, each followed by a 1-cycle 0 gap; newGame pulsed once before first request.
- Player bust:
  - Stimulus: P1 hands 10 then 20, hit gives 26/0.
  - Required: auto-advance to P2, activePlayer=2; final p1_result=1.
- Dealer draw:
  - Stimulus: dealer hands 12 then 16 then 22/12, then 19.
  - Required: draws until 19, then stops; vs P2=19 -> p2_result=2.
  - Soft-17 check: d_high=17, d_low=7.
    - Macro defined: one more draw.
    - Macro undefined: stands.
- Both players bust:
  - Required: no userSelect=3 request after deal; both results=1.
- Timeout:
  - Stimulus: no cardsUpdated after a request.
  - Required: after 64 cycles error=1, userSelect=0, done=1, results=0.
- Async reset:
  - Stimulus: reset=0 during dealer REQ.
  - Required: userSelect=0 the same cycle, all outputs 0.
- Dropped input:
  - Stimulus: hit during a draw in flight.
  - Required: no extra request issued.
